// File: rtl/axis_tcp_word_bridge.sv
// axis_tcp_word_bridge
//   Buffers 32-bit words between the VPI TCP server poll loop and an AXI-Stream
//   DUT. Words received from the TCP server enter an RX FIFO and are presented on
//   m_axis. Words accepted on s_axis wait in a TX FIFO until the bench sends and
//   acknowledges them.
//
// Parameters
//   BUS_WIDTH   word width in bytes (data ports are BUS_WIDTH*8 bits)
//   FIFO_DEPTH  entries per FIFO, power of two, >= 2
//
// Ports
//   aclk, arstn      clock (rising edge) and synchronous active-low reset
//   rx_data/valid    word from $recv_tcp_server, one-cycle valid pulse
//   rx_ready         RX FIFO has room
//   rx_drop_count    saturating count of words dropped at the RX input
//   m_axis_*         RX FIFO head towards the DUT (tdata/tvalid/tready/tlast)
//   s_axis_*         words from the DUT into the TX FIFO (tdata/tvalid/tready)
//   tx_data/valid    TX FIFO head for $send_tcp_server
//   tx_ack           bench has sent tx_data; pops the TX FIFO when tx_valid
//
// Build option
//   AXIS_TCP_WORD_BRIDGE_FRAME_EN: when defined, RX words are length-prefixed
//   frames. Header words are consumed internally and m_axis_tlast marks the last
//   payload word. When undefined, every RX word is payload and tlast stays 0.

module axis_tcp_word_bridge #(
  parameter int BUS_WIDTH  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic [BUS_WIDTH*8-1:0] rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             rx_drop_count,
  output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [BUS_WIDTH*8-1:0] tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ack
);

  localparam int DW = BUS_WIDTH * 8;
  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]   rx_wr_ptr;
  logic [AW:0]   rx_rd_ptr;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_push;
  logic          rx_pop;
  logic [DW-1:0] rx_head;

  // Full/empty come only from registered pointers, so a pop in the same cycle
  // never raises rx_ready early and a push never bypasses to m_axis.
  assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                    (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_head  = rx_mem[rx_rd_ptr[AW-1:0]];

  assign m_axis_tdata = rx_head;

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_data;
  end

  // Words offered while the FIFO is full are lost; count them, holding at 255.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      rx_drop_count <= '0;
    end else if (rx_valid && !rx_ready && (rx_drop_count != 8'hFF)) begin
      rx_drop_count <= rx_drop_count + 8'd1;
    end
  end

`ifdef AXIS_TCP_WORD_BRIDGE_FRAME_EN
  // ---------------------------------------------------------------------------
  // Framing FSM: HDR consumes a length word, PAYLOAD passes that many words.
  // ---------------------------------------------------------------------------
  typedef enum logic {HDR = 1'b0, PAYLOAD = 1'b1} frame_state_t;

  frame_state_t  state;
  frame_state_t  state_next;
  logic [DW-1:0] remaining;
  logic [DW-1:0] remaining_next;

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state     <= HDR;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  // A zero-length header is consumed and leaves the FSM in HDR.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    rx_pop         = 1'b0;
    case (state)
      HDR: begin
        if (!rx_empty) begin
          rx_pop = 1'b1;
          if (rx_head != '0) begin
            remaining_next = rx_head;
            state_next     = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        m_axis_tvalid = !rx_empty;
        m_axis_tlast  = (remaining == DW'(1)) && m_axis_tvalid;
        if (m_axis_tvalid && m_axis_tready) begin
          rx_pop         = 1'b1;
          remaining_next = remaining - DW'(1);
          if (remaining == DW'(1)) state_next = HDR;
        end
      end
      default: state_next = HDR;
    endcase
  end
`else
  // Without framing, the RX FIFO head goes straight to m_axis.
  assign m_axis_tvalid = !rx_empty;
  assign m_axis_tlast  = 1'b0;
  assign rx_pop        = m_axis_tvalid && m_axis_tready;
`endif

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]   tx_wr_ptr;
  logic [AW:0]   tx_rd_ptr;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push;
  logic          tx_pop;

  assign tx_full       = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                         (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
  assign tx_empty      = (tx_wr_ptr == tx_rd_ptr);
  assign s_axis_tready = !tx_full;
  assign tx_valid      = !tx_empty;
  assign tx_push       = s_axis_tvalid && s_axis_tready;
  // An ack with nothing queued must not move the read pointer.
  assign tx_pop        = tx_ack && tx_valid;
  assign tx_data       = tx_mem[tx_rd_ptr[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_axis_tcp_word_bridge.sv
// tb_axis_tcp_word_bridge
//   Self-checking bench for axis_tcp_word_bridge (BUS_WIDTH=4, FIFO_DEPTH=16).
//   A reference model keeps RX/TX word queues, the drop counter and (when
//   AXIS_TCP_WORD_BRIDGE_FRAME_EN is defined) the framing state. Each cycle the
//   bench drives inputs on the falling edge and compares the DUT outputs with
//   the model. It then advances the model across the rising edge.

module tb_axis_tcp_word_bridge;

  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        arstn;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_drop_count;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ack;

  axis_tcp_word_bridge #(.BUS_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_drop_count (rx_drop_count),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ack        (tx_ack)
  );

  always #5 aclk = ~aclk;

  int assert_count = 0;
  int fail_count   = 0;

  // Scoreboard and reference model state.
  logic [31:0] rx_q[$];
  logic [31:0] tx_q[$];
  logic [31:0] seen_q[$];
  logic        seen_last_q[$];
  int          drop_model;
  bit          m_payload;
  int          m_rem;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic clearModel();
    rx_q.delete();
    tx_q.delete();
    drop_model = 0;
    m_payload  = 1'b0;
    m_rem      = 0;
  endtask

  // One clock cycle. Drive the inputs, compare the outputs, then advance the model.
  task automatic applyStimulus(input logic rxv, input logic [31:0] rxd,
                               input logic trdy, input logic sv,
                               input logic [31:0] sd, input logic ack);
    bit exp_rx_ready, exp_mvalid, exp_mlast, exp_s_ready, exp_tx_valid;
    bit rx_acc, rx_drop, hdr_take, pay_pop, tx_acc, tx_pop;
    logic [31:0] h;
    @(negedge aclk);
    rx_valid      = rxv;
    rx_data       = rxd;
    m_axis_tready = trdy;
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    tx_ack        = ack;
    #1;
    exp_rx_ready = (rx_q.size() != DEPTH);
`ifdef AXIS_TCP_WORD_BRIDGE_FRAME_EN
    exp_mvalid = m_payload && (rx_q.size() != 0);
    exp_mlast  = exp_mvalid && (m_rem == 1);
    hdr_take   = !m_payload && (rx_q.size() != 0);
`else
    exp_mvalid = (rx_q.size() != 0);
    exp_mlast  = 1'b0;
    hdr_take   = 1'b0;
`endif
    exp_s_ready  = (tx_q.size() != DEPTH);
    exp_tx_valid = (tx_q.size() != 0);

    checkOutput("rx_ready", {31'b0, rx_ready}, {31'b0, exp_rx_ready});
    checkOutput("m_tvalid", {31'b0, m_axis_tvalid}, {31'b0, exp_mvalid});
    checkOutput("m_tlast", {31'b0, m_axis_tlast}, {31'b0, exp_mlast});
    checkOutput("drop_count", {24'b0, rx_drop_count}, drop_model[31:0]);
    checkOutput("s_tready", {31'b0, s_axis_tready}, {31'b0, exp_s_ready});
    checkOutput("tx_valid", {31'b0, tx_valid}, {31'b0, exp_tx_valid});
    if (exp_mvalid) checkOutput("m_tdata", m_axis_tdata, rx_q[0]);
    if (exp_tx_valid) checkOutput("tx_data", tx_data, tx_q[0]);

    if (m_axis_tvalid && trdy) begin
      seen_q.push_back(m_axis_tdata);
      seen_last_q.push_back(m_axis_tlast);
    end

    rx_acc  = rxv && exp_rx_ready;
    rx_drop = rxv && !exp_rx_ready;
    pay_pop = exp_mvalid && trdy;
    tx_acc  = sv && exp_s_ready;
    tx_pop  = ack && exp_tx_valid;

    @(posedge aclk);
    if (hdr_take) begin
      h = rx_q.pop_front();
      if (h != 0) begin
        m_payload = 1'b1;
        m_rem     = int'(h);
      end
    end
    if (pay_pop) begin
      void'(rx_q.pop_front());
      if (m_rem == 1) m_payload = 1'b0;
      m_rem--;
    end
    if (rx_acc) rx_q.push_back(rxd);
    if (rx_drop && drop_model < 255) drop_model++;
    if (tx_pop) void'(tx_q.pop_front());
    if (tx_acc) tx_q.push_back(sd);
  endtask

  task automatic idle(input int n, input logic trdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, trdy, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resetDut();
    @(negedge aclk);
    arstn = 1'b0;
    rx_valid = 1'b0; m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; tx_ack = 1'b0;
    rx_data = '0; s_axis_tdata = '0;
    @(posedge aclk);
    #1;
    checkOutput("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    checkOutput("rst_s_tready", {31'b0, s_axis_tready}, 32'd1);
    checkOutput("rst_m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("rst_m_tlast", {31'b0, m_axis_tlast}, 32'd0);
    checkOutput("rst_drop", {24'b0, rx_drop_count}, 32'd0);
    clearModel();
    arstn = 1'b1;
  endtask

  // TX path: three words out, acked as they appear, then a stray ack on empty.
  task automatic txTest();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h2, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h3, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, tx_q.size() != 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);
    idle(1, 1'b0);
    checkOutput("tx_after_stray_ack", tx_data, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(1, 1'b0);
  endtask

  initial begin
    arstn = 1'b1;
    rx_valid = 1'b0; rx_data = '0; m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; tx_ack = 1'b0;
    clearModel();
    resetDut();

`ifdef AXIS_TCP_WORD_BRIDGE_FRAME_EN
    $display("[TB] framing build");
    // Frames: [2: A B] [0] [1: C]
    seen_q.delete(); seen_last_q.delete();
    applyStimulus(1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'hA, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(8, 1'b1);
    checkOutput("frame_words", seen_q.size(), 32'd3);
    if (seen_q.size() == 3) begin
      checkOutput("frame_w0", seen_q[0], 32'hA);
      checkOutput("frame_w1", seen_q[1], 32'hB);
      checkOutput("frame_w2", seen_q[2], 32'hC);
      checkOutput("frame_l0", {31'b0, seen_last_q[0]}, 32'd0);
      checkOutput("frame_l1", {31'b0, seen_last_q[1]}, 32'd1);
      checkOutput("frame_l2", {31'b0, seen_last_q[2]}, 32'd1);
    end

    // Reset in the middle of a 3-word frame; the next word is a header again.
    applyStimulus(1'b1, 32'h3, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2, 1'b0);
    resetDut();
    seen_q.delete(); seen_last_q.delete();
    applyStimulus(1'b1, 32'h1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(4, 1'b1);
    checkOutput("postrst_words", seen_q.size(), 32'd1);
    if (seen_q.size() == 1) begin
      checkOutput("postrst_w0", seen_q[0], 32'h22);
      checkOutput("postrst_l0", {31'b0, seen_last_q[0]}, 32'd1);
    end
`else
    $display("[TB] plain build");
    // Single word, latency 1.
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(3, 1'b1);

    // Overfill by one with the sink stalled, then drain.
    for (int i = 0; i < 17; i++)
      applyStimulus(1'b1, 32'h100 + i, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1, 1'b0);
    checkOutput("drop_after_17", {24'b0, rx_drop_count}, 32'd1);
    idle(18, 1'b1);

    // Refill, then push and pop together from full.
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 32'h200 + i, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h300 + i, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(20, 1'b1);
`endif

    txTest();

    // Mixed random traffic on both paths.
    for (int i = 0; i < 120; i++)
      applyStimulus($urandom_range(0, 1) != 0, $urandom, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) != 0, $urandom, $urandom_range(0, 3) == 0);
    idle(40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
